// File: rtl/reg_file_mp.sv
// Multi-ported register file with per-register scoreboard busy bits.
// Register 0 is hardwired to zero. Write ports are indexed, and the highest index wins on a collision.
module reg_file_mp #(
    parameter int REG_WIDTH  = 32,
    parameter int FILE_DEPTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int REG_OUTPUT = 0,
    parameter int BYPASS     = 1,
    localparam int ADDR_WIDTH = $clog2(FILE_DEPTH)
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0]  o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_busy,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0]  i_wr_data,
    input  logic                         i_issue_en,
    input  logic [ADDR_WIDTH-1:0]        i_issue_addr,
    input  logic                         i_flush
);

    logic [REG_WIDTH-1:0]     r_regs [FILE_DEPTH];
    logic [FILE_DEPTH-1:0]    r_busy;
    logic [NUM_RD*REG_WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]           w_rd_busy;

    // Ascending port order makes the last non-blocking write (the highest port) win.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FILE_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    r_regs[i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wr_data[j*REG_WIDTH +: REG_WIDTH];
                end
            end
        end
    end

    // Write-back clears and issue sets afterwards, so issue wins on the same register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (i_wr_en[j]) begin
                    r_busy[i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
                end
            end
            if (i_issue_en) begin
                r_busy[i_issue_addr] <= 1'b1;
            end
            r_busy[0] <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [REG_WIDTH-1:0]  w_data;
        logic                  w_hit;
        logic                  w_busy;

        assign w_addr = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_data = r_regs[w_addr];
            w_hit  = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == w_addr)) begin
                    w_hit = 1'b1;
                    if (BYPASS != 0) begin
                        w_data = i_wr_data[j*REG_WIDTH +: REG_WIDTH];
                    end
                end
            end
            if (w_addr == '0) begin
                w_data = '0;
                w_hit  = 1'b0;
            end
            w_busy = r_busy[w_addr];
            if ((BYPASS != 0) && w_hit && !(i_issue_en && (i_issue_addr == w_addr))) begin
                w_busy = 1'b0;
            end
        end

        // Held at zero during reset so same-cycle bypass cannot leak write data.
        assign w_rd_data[k*REG_WIDTH +: REG_WIDTH] = i_reset_n ? w_data : '0;
        assign w_rd_busy[k]                        = i_reset_n ? w_busy : 1'b0;
    end

    if (REG_OUTPUT != 0) begin : g_out_reg
        logic [NUM_RD*REG_WIDTH-1:0] r_rd_data;
        logic [NUM_RD-1:0]           r_rd_busy;

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_rd_data <= '0;
                r_rd_busy <= '0;
            end else begin
                r_rd_data <= w_rd_data;
                r_rd_busy <= w_rd_busy;
            end
        end

        assign o_rd_data = r_rd_data;
        assign o_rd_busy = r_rd_busy;
    end else begin : g_out_comb
        assign o_rd_data = w_rd_data;
        assign o_rd_busy = w_rd_busy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: four instances (bypass on/off x combinational/registered read) share one stimulus stream.
module tb_reg_file_mp;
    localparam int RW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NWR-1:0]     wr_en;
    logic [NWR*AW-1:0]  wr_addr;
    logic [NWR*RW-1:0]  wr_data;
    logic               issue_en;
    logic [AW-1:0]      issue_addr;
    logic               flush;
    logic [NRD*RW-1:0]  rdata [4];
    logic [NRD-1:0]     rbusy [4];

    // 0: bypass/comb, 1: no-bypass/comb, 2: bypass/registered, 3: no-bypass/registered
    reg_file_mp #(.REG_WIDTH(RW), .FILE_DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR), .REG_OUTPUT(0), .BYPASS(1)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rdata[0]), .o_rd_busy(rbusy[0]),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_issue_en(issue_en),
        .i_issue_addr(issue_addr), .i_flush(flush));
    reg_file_mp #(.REG_WIDTH(RW), .FILE_DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR), .REG_OUTPUT(0), .BYPASS(0)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rdata[1]), .o_rd_busy(rbusy[1]),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_issue_en(issue_en),
        .i_issue_addr(issue_addr), .i_flush(flush));
    reg_file_mp #(.REG_WIDTH(RW), .FILE_DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR), .REG_OUTPUT(1), .BYPASS(1)) u_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rdata[2]), .o_rd_busy(rbusy[2]),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_issue_en(issue_en),
        .i_issue_addr(issue_addr), .i_flush(flush));
    reg_file_mp #(.REG_WIDTH(RW), .FILE_DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR), .REG_OUTPUT(1), .BYPASS(0)) u_d (
        .i_clk(clk), .i_reset_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rdata[3]), .o_rd_busy(rbusy[3]),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_issue_en(issue_en),
        .i_issue_addr(issue_addr), .i_flush(flush));

    // Reference model: architectural register array, busy array, and values captured for the registered instances.
    logic [RW-1:0] m_regs [DEPTH];
    logic          m_busy [DEPTH];
    logic [RW-1:0] m_q_data [2][NRD];
    logic          m_q_busy [2][NRD];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [AW-1:0] rd_a(int p);
        return rd_addr[p*AW +: AW];
    endfunction

    function automatic logic [RW-1:0] comb_data(int p, bit byp);
        logic [AW-1:0] a;
        logic [RW-1:0] v;
        a = rd_a(p);
        if (!rst_n || a == 0) return '0;
        v = m_regs[a];
        if (byp)
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*RW +: RW];
        return v;
    endfunction

    function automatic logic comb_busy(int p, bit byp);
        logic [AW-1:0] a;
        bit hit;
        a = rd_a(p);
        hit = 0;
        if (!rst_n || a == 0) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) hit = 1;
        if (byp && hit && !(issue_en && issue_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [RW-1:0] exp_data(int inst, int p);
        case (inst)
            0:       return comb_data(p, 1);
            1:       return comb_data(p, 0);
            2:       return m_q_data[0][p];
            default: return m_q_data[1][p];
        endcase
    endfunction

    function automatic logic exp_busy(int inst, int p);
        case (inst)
            0:       return comb_busy(p, 1);
            1:       return comb_busy(p, 0);
            2:       return m_q_busy[0][p];
            default: return m_q_busy[1][p];
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < NRD; p++) begin
                m_q_data[b][p] = '0;
                m_q_busy[b][p] = 1'b0;
            end
    endtask

    task automatic set_idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_clear();
    endtask

    // Advance one rising edge and apply the architectural update rules to the model.
    task automatic tick();
        logic [RW-1:0] qd [2][NRD];
        logic          qb [2][NRD];
        for (int p = 0; p < NRD; p++) begin
            qd[0][p] = comb_data(p, 1); qd[1][p] = comb_data(p, 0);
            qb[0][p] = comb_busy(p, 1); qb[1][p] = comb_busy(p, 0);
        end
        @(posedge clk);
        if (rst_n) begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_regs[wr_addr[j*AW +: AW]] = wr_data[j*RW +: RW];
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else begin
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
                if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            end
            m_q_data = qd;
            m_q_busy = qb;
        end
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        wr_en = 2'b11; wr_addr = {4'd5, 4'd5}; wr_data = {32'h1111_2222, 32'h3333_4444};
        issue_en = 1'b1; issue_addr = 4'd5; rd_addr = {4'd5, 4'd5};
        #2;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdata[i] !== '0 || rbusy[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_out inst%0d: got data %h busy %b want 0", i, rdata[i], rbusy[i]);
            end
        end
        tick();
        rst_n = 1'b1;
        set_idle();
        rd_addr = {4'd5, 4'd5};
        #2;
        n_checks++;
        if (rdata[0][31:0] !== 32'h0 || rbusy[0][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignore_wr: got data %h busy %b want 0/0", rdata[0][31:0], rbusy[0][0]);
        end
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 2'b11; wr_addr = {4'd0, 4'd5}; wr_data = {32'h0000_1111, 32'hDEAD_BEEF};
        rd_addr = {4'd0, 4'd3};
        #2;
        n_checks++;
        if (rdata[0][63:32] !== 32'h0) begin
            n_fail++; $display("FAIL r0_bypass: got %h want 0", rdata[0][63:32]);
        end
        tick();
        set_idle();
        rd_addr = {4'd5, 4'd5};
        #2;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rdata[i] !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
                n_fail++; $display("FAIL wr_rd inst%0d: got %h want deadbeef on both ports", i, rdata[i]);
            end
        end
        tick();
        rd_addr = {4'd0, 4'd0};
        #2;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdata[i] !== (i >= 2 ? {32'hDEAD_BEEF, 32'hDEAD_BEEF} : 64'h0)) begin
                n_fail++; $display("FAIL wr_rd_lat inst%0d: got %h (comb wants 0 from r0, registered wants deadbeef)", i, rdata[i]);
            end
        end
        tick();
    endtask

    task automatic test_bypass();
        wr_en = 2'b01; wr_addr = {4'd0, 4'd7}; wr_data = {32'h0, 32'h0000_1234};
        rd_addr = {4'd7, 4'd7};
        #2;
        n_checks++;
        if (rdata[0][31:0] !== 32'h1234) begin
            n_fail++; $display("FAIL bypass_on: got %h want 1234", rdata[0][31:0]);
        end
        n_checks++;
        if (rdata[1][31:0] !== 32'h0) begin
            n_fail++; $display("FAIL bypass_off: got %h want 0", rdata[1][31:0]);
        end
        tick();
        wr_en = '0;
        #2;
        n_checks++;
        if (rdata[2][31:0] !== 32'h1234 || rdata[3][31:0] !== 32'h0 || rdata[1][31:0] !== 32'h1234) begin
            n_fail++;
            $display("FAIL bypass_reg: got c=%h d=%h b=%h want 1234/0/1234", rdata[2][31:0], rdata[3][31:0], rdata[1][31:0]);
        end
        tick();
        n_checks++;
        if (rdata[3][63:32] !== 32'h1234) begin
            n_fail++; $display("FAIL bypass_reg_late: got %h want 1234", rdata[3][63:32]);
        end
        set_idle();
    endtask

    task automatic test_dual_write();
        wr_en = 2'b11; wr_addr = {4'd3, 4'd3}; wr_data = {32'hB, 32'hA};
        rd_addr = {4'd3, 4'd3};
        #2;
        n_checks++;
        if (rdata[0][31:0] !== 32'hB) begin
            n_fail++; $display("FAIL dual_bypass: got %h want b", rdata[0][31:0]);
        end
        tick();
        wr_en = '0;
        #2;
        n_checks++;
        if (rdata[1][31:0] !== 32'hB || rdata[2][63:32] !== 32'hB) begin
            n_fail++; $display("FAIL dual_wr: got b=%h c=%h want b/b", rdata[1][31:0], rdata[2][63:32]);
        end
        tick();
        set_idle();
    endtask

    task automatic test_busy();
        issue_en = 1'b1; issue_addr = 4'd9; rd_addr = {4'd0, 4'd9};
        #2;
        n_checks++;
        if (rbusy[0][0] !== 1'b0) begin
            n_fail++; $display("FAIL busy_pre: got %b want 0", rbusy[0][0]);
        end
        tick();
        issue_en = 1'b0;
        #2;
        n_checks++;
        if (rbusy[0][0] !== 1'b1 || rbusy[1][0] !== 1'b1) begin
            n_fail++; $display("FAIL busy_set: got a=%b b=%b want 1/1", rbusy[0][0], rbusy[1][0]);
        end
        tick();
        wr_en = 2'b01; wr_addr = {4'd0, 4'd9}; wr_data = {32'h0, 32'h99};
        #2;
        n_checks++;
        if (rbusy[0][0] !== 1'b0 || rbusy[1][0] !== 1'b1) begin
            n_fail++; $display("FAIL busy_wb_same: got a=%b b=%b want 0/1", rbusy[0][0], rbusy[1][0]);
        end
        tick();
        wr_en = '0;
        #2;
        n_checks++;
        if (rbusy[0][0] !== 1'b0 || rbusy[1][0] !== 1'b0 || rbusy[2][0] !== 1'b0 || rbusy[3][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_wb_after: got a=%b b=%b c=%b d=%b want 0/0/0/1", rbusy[0][0], rbusy[1][0], rbusy[2][0], rbusy[3][0]);
        end
        issue_en = 1'b1;
        tick();
        wr_en = 2'b10; wr_addr = {4'd9, 4'd0}; wr_data = {32'h9A, 32'h0};
        #2;
        n_checks++;
        if (rbusy[0][0] !== 1'b1) begin
            n_fail++; $display("FAIL busy_issue_wins_now: got %b want 1", rbusy[0][0]);
        end
        tick();
        set_idle();
        rd_addr = {4'd0, 4'd9};
        #2;
        n_checks++;
        if (rbusy[0][0] !== 1'b1 || rdata[0][31:0] !== 32'h9A) begin
            n_fail++; $display("FAIL busy_issue_wins: got busy %b data %h want 1/9a", rbusy[0][0], rdata[0][31:0]);
        end
        tick();
        set_idle();
    endtask

    task automatic test_flush();
        wr_en = 2'b11; wr_addr = {4'd4, 4'd2}; wr_data = {32'h44, 32'h22};
        tick();
        set_idle();
        issue_en = 1'b1; issue_addr = 4'd2;
        tick();
        issue_addr = 4'd4;
        tick();
        issue_en = 1'b0; rd_addr = {4'd4, 4'd2};
        #2;
        n_checks++;
        if (rbusy[0] !== 2'b11) begin
            n_fail++; $display("FAIL flush_pre: got %b want 11", rbusy[0]);
        end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 4'd6;
        tick();
        flush = 1'b0; issue_en = 1'b0;
        #2;
        n_checks++;
        if (rbusy[0] !== 2'b00 || rdata[0] !== {32'h44, 32'h22}) begin
            n_fail++; $display("FAIL flush: got busy %b data %h want 00 / 44,22", rbusy[0], rdata[0]);
        end
        rd_addr = {4'd6, 4'd6};
        #1;
        n_checks++;
        if (rbusy[0][1] !== 1'b0) begin
            n_fail++; $display("FAIL flush_over_issue: got %b want 0", rbusy[0][1]);
        end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid();
        wr_en = 2'b01; wr_addr = {4'd0, 4'd1}; wr_data = {32'h0, 32'h55};
        tick();
        set_idle();
        rd_addr = {4'd1, 4'd1};
        tick();
        #1;
        n_checks++;
        if (rdata[2][31:0] !== 32'h55) begin
            n_fail++; $display("FAIL mid_pre: got %h want 55", rdata[2][31:0]);
        end
        wr_en = 2'b01; wr_data = {32'h0, 32'h77}; wr_addr = {4'd0, 4'd1}; issue_en = 1'b1; issue_addr = 4'd1;
        assert_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdata[i] !== '0 || rbusy[i] !== '0) begin
                n_fail++; $display("FAIL mid_reset inst%0d: got data %h busy %b want 0", i, rdata[i], rbusy[i]);
            end
        end
        tick();
        rst_n = 1'b1;
        set_idle();
        rd_addr = {4'd1, 4'd1};
        #2;
        n_checks++;
        if (rdata[0][31:0] !== 32'h0 || rbusy[0][0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: got %h busy %b want 0/0", rdata[0][31:0], rbusy[0][0]);
        end
        tick();
        n_checks++;
        if (rdata[2][31:0] !== 32'h0) begin
            n_fail++; $display("FAIL mid_release_reg: got %h want 0", rdata[2][31:0]);
        end
        set_idle();
    endtask

    task automatic test_random(int n);
        int s;
        for (int c = 0; c < n; c++) begin
            wr_en = 2'($urandom_range(0, 3));
            for (int j = 0; j < NWR; j++) begin
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
                wr_data[j*RW +: RW] = $urandom();
            end
            for (int p = 0; p < NRD; p++) begin
                s = $urandom_range(0, 1);
                if ($urandom_range(0, 2) == 0) rd_addr[p*AW +: AW] = wr_addr[s*AW +: AW];
                else rd_addr[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
            end
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = ($urandom_range(0, 1) == 1) ? rd_addr[AW-1:0] : AW'($urandom_range(0, DEPTH - 1));
            flush      = ($urandom_range(0, 19) == 0);
            #2;
            for (int i = 0; i < 4; i++)
                for (int p = 0; p < NRD; p++) begin
                    n_checks++;
                    if (rdata[i][p*RW +: RW] !== exp_data(i, p) || rbusy[i][p] !== exp_busy(i, p)) begin
                        n_fail++;
                        $display("FAIL rand c%0d inst%0d port%0d: got data %h busy %b want %h %b",
                                 c, i, p, rdata[i][p*RW +: RW], rbusy[i][p], exp_data(i, p), exp_busy(i, p));
                    end
                end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_clear();
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_dual_write();
        test_busy();
        test_flush();
        test_reset_mid();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
